// File: rtl/mlp_pkg.sv
// Shared types, defaults and requantisation helper for the MNIST MLP datapath.
// Used by the dense-layer engine, the board top and the other layers.
package mlp_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WEIGHT_W = 8;
    localparam int DEF_ACC_W    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    // Shift, optional ReLU, then clamp to a signed data_w-bit range.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 data_w,
        input bit                 relu
    );
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = acc >>> shift;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (relu && y < 0)
            y = '0;
        if (y > hi)
            y = hi;
        else if (y < lo)
            y = lo;
        return y;
    endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Input extension, signed multiply and bias-seeded accumulate.
// load selects the bias as the base for the first product of a neuron.
module mlp_mac_unit #(
    parameter int DATA_W      = 8,
    parameter int WEIGHT_W    = 8,
    parameter int BIAS_W      = 16,
    parameter int ACC_W       = 32,
    parameter int IN_UNSIGNED = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       en,
    input  logic [DATA_W-1:0]          in_data,
    input  logic signed [WEIGHT_W-1:0] w_data,
    input  logic signed [BIAS_W-1:0]   b_data,
    output logic signed [ACC_W-1:0]    acc
);

    logic signed [DATA_W:0]          x_ext;
    logic signed [DATA_W+WEIGHT_W:0] prod;
    logic signed [ACC_W-1:0]         base;

    assign x_ext = (IN_UNSIGNED != 0) ? $signed({1'b0, in_data})
                                      : $signed({in_data[DATA_W-1], in_data});
    assign prod  = x_ext * w_data;
    assign base  = load ? ACC_W'(b_data) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= base + ACC_W'(prod);
    end

endmodule

// File: rtl/mlp_dense_layer.sv
// Fully-connected layer engine: per-neuron bias + dot product, requantise,
// write out, and track the argmax class across neurons.
module mlp_dense_layer
    import mlp_pkg::*;
#(
    parameter int N_IN        = 784,
    parameter int N_OUT       = 10,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WEIGHT_W    = DEF_WEIGHT_W,
    parameter int BIAS_W      = 16,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int FRAC_SHIFT  = 7,
    parameter int RELU        = 1,
    parameter int IN_UNSIGNED = 1,
    parameter int IDX_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    parameter int IN_AW       = $clog2(N_IN),
    parameter int W_AW        = $clog2(N_IN * N_OUT)
) (
    input  logic                       CLOCK_50,
    input  logic                       KEY,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [IN_AW-1:0]           in_addr,
    input  logic [DATA_W-1:0]          in_data,
    output logic [W_AW-1:0]            w_addr,
    input  logic signed [WEIGHT_W-1:0] w_data,
    output logic [IDX_W-1:0]           b_addr,
    input  logic signed [BIAS_W-1:0]   b_data,
    output logic                       out_we,
    output logic [IDX_W-1:0]           out_addr,
    output logic signed [DATA_W-1:0]   out_data,
    output logic [IDX_W-1:0]           class_idx
);

    localparam logic [IN_AW-1:0] I_LAST = IN_AW'(N_IN - 1);
    localparam logic [IN_AW-1:0] I_PEN  = IN_AW'(N_IN - 2);
    localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_OUT - 1);

    state_t                   state;
    logic [IN_AW-1:0]         i;
    logic [IDX_W-1:0]         j;
    logic [IDX_W-1:0]         best_idx;
    logic signed [ACC_W-1:0]  best_acc;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] y_q;
    logic                     new_best;

    mlp_mac_unit #(
        .DATA_W     (DATA_W),
        .WEIGHT_W   (WEIGHT_W),
        .BIAS_W     (BIAS_W),
        .ACC_W      (ACC_W),
        .IN_UNSIGNED(IN_UNSIGNED)
    ) u_mac (
        .clk    (CLOCK_50),
        .rst_n  (KEY),
        .load   (i == '0),
        .en     (state == S_MAC),
        .in_data(in_data),
        .w_data (w_data),
        .b_data (b_data),
        .acc    (acc)
    );

    assign y_q      = DATA_W'(requant(64'(acc), FRAC_SHIFT, DATA_W, RELU != 0));
    assign new_best = (j == '0) || (acc > best_acc);

    // Addresses run one step ahead of the MAC to cover the 1-cycle read latency.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state     <= S_IDLE;
            i         <= '0;
            j         <= '0;
            best_idx  <= '0;
            best_acc  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            b_addr    <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            class_idx <= '0;
        end else begin
            out_we <= 1'b0;
            busy   <= state inside {S_BIAS, S_MAC, S_WRITE};
            done   <= state == S_DONE;
            unique case (state)
                S_IDLE: begin
                    best_idx <= '0;
                    best_acc <= '0;
                    if (start) begin
                        state   <= S_BIAS;
                        j       <= '0;
                        b_addr  <= '0;
                        in_addr <= '0;
                        w_addr  <= '0;
                    end
                end
                S_BIAS: begin
                    state   <= S_MAC;
                    i       <= '0;
                    in_addr <= IN_AW'(1);
                    w_addr  <= w_addr + 1'b1;
                end
                S_MAC: begin
                    i <= i + 1'b1;
                    if (i < I_PEN) begin
                        in_addr <= in_addr + 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end
                    if (i == I_LAST)
                        state <= S_WRITE;
                end
                S_WRITE: begin
                    out_we   <= 1'b1;
                    out_addr <= j;
                    out_data <= y_q;
                    if (new_best) begin
                        best_idx <= j;
                        best_acc <= acc;
                    end
                    if (j == J_LAST) begin
                        state     <= S_DONE;
                        class_idx <= new_best ? j : best_idx;
                    end else begin
                        state   <= S_BIAS;
                        j       <= j + 1'b1;
                        b_addr  <= j + 1'b1;
                        in_addr <= '0;
                        w_addr  <= w_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_dense_layer.sv
// Scoreboard bench: two layer instances (ReLU/unsigned and linear/signed)
// run in lockstep on shared directed vectors.
module tb_mlp_dense_layer;

    localparam int NI = 4;
    localparam int NO = 3;

    typedef struct {
        int addr;
        int d0;
        int d1;
    } wr_t;

    typedef struct {
        int c0;
        int c1;
    } cl_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    logic              busy      [2];
    logic              done      [2];
    logic              out_we    [2];
    logic [1:0]        in_addr   [2];
    logic [3:0]        w_addr    [2];
    logic [1:0]        b_addr    [2];
    logic [1:0]        out_addr  [2];
    logic [1:0]        class_idx [2];
    logic signed [7:0] out_data  [2];
    logic [7:0]        in_data   [2];
    logic signed [7:0] w_data    [2];
    logic signed [15:0] b_data   [2];

    logic [7:0]  xm [4];
    logic [7:0]  wm [16];
    logic [15:0] bm [4];

    wr_t wq[$];
    cl_t cq[$];
    int  nvec = 0;
    int  errs = 0;
    logic done_q = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mlp_dense_layer #(
            .N_IN       (NI),
            .N_OUT      (NO),
            .DATA_W     (8),
            .WEIGHT_W   (8),
            .BIAS_W     (16),
            .ACC_W      (32),
            .FRAC_SHIFT (0),
            .RELU       ((k == 0) ? 1 : 0),
            .IN_UNSIGNED((k == 0) ? 1 : 0)
        ) dut (
            .CLOCK_50 (clk),
            .KEY      (rst_n),
            .start    (start),
            .busy     (busy[k]),
            .done     (done[k]),
            .in_addr  (in_addr[k]),
            .in_data  (in_data[k]),
            .w_addr   (w_addr[k]),
            .w_data   (w_data[k]),
            .b_addr   (b_addr[k]),
            .b_data   (b_data[k]),
            .out_we   (out_we[k]),
            .out_addr (out_addr[k]),
            .out_data (out_data[k]),
            .class_idx(class_idx[k])
        );
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            in_data[k] <= xm[in_addr[k]];
            w_data[k]  <= $signed(wm[w_addr[k]]);
            b_data[k]  <= $signed(bm[b_addr[k]]);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        cl_t c;
        if (out_we[0] || out_we[1]) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = wq.pop_front();
                chk("we_relu", int'(out_we[0]), 1);
                chk("we_lin", int'(out_we[1]), 1);
                chk("addr_relu", int'(out_addr[0]), e.addr);
                chk("addr_lin", int'(out_addr[1]), e.addr);
                chk("data_relu", int'(out_data[0]), e.d0);
                chk("data_lin", int'(out_data[1]), e.d1);
            end
        end
        if (done[0] && !done_q) begin
            if (cq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                c = cq.pop_front();
                chk("class_relu", int'(class_idx[0]), c.c0);
                chk("class_lin", int'(class_idx[1]), c.c1);
            end
        end
        done_q = done[0];
    end

    task automatic set_x(input int a, input int b, input int c, input int d);
        xm[0] = 8'(a);
        xm[1] = 8'(b);
        xm[2] = 8'(c);
        xm[3] = 8'(d);
    endtask

    task automatic set_row(input int r, input int a, input int b,
                           input int c, input int d);
        wm[r*4+0] = 8'(a);
        wm[r*4+1] = 8'(b);
        wm[r*4+2] = 8'(c);
        wm[r*4+3] = 8'(d);
    endtask

    task automatic set_b(input int a, input int b, input int c);
        bm[0] = 16'(a);
        bm[1] = 16'(b);
        bm[2] = 16'(c);
    endtask

    task automatic exp_wr(input int addr, input int d0, input int d1);
        wr_t e;
        e.addr = addr;
        e.d0   = d0;
        e.d1   = d1;
        wq.push_back(e);
    endtask

    task automatic exp_cl(input int c0, input int c1);
        cl_t c;
        c.c0 = c0;
        c.c1 = c1;
        cq.push_back(c);
    endtask

    // Expected columns: address, ReLU/unsigned instance, linear/signed instance.
    task automatic load_vec(input int v);
        case (v)
            1: begin
                set_x(1, 2, 3, 4);
                set_row(0, 1, 1, 1, 1);
                set_row(1, 0, 0, 0, 0);
                set_row(2, 30, 30, 30, 30);
                set_b(0, -50, 0);
                exp_wr(0, 10, 10);
                exp_wr(1, 0, -50);
                exp_wr(2, 127, 127);
                exp_cl(2, 2);
            end
            2: begin
                set_x(1, 1, 1, 1);
                set_row(0, 0, 0, 0, 0);
                set_row(1, 0, 0, 0, 0);
                set_row(2, 0, 0, 0, 0);
                set_b(5, 9, 9);
                exp_wr(0, 5, 5);
                exp_wr(1, 9, 9);
                exp_wr(2, 9, 9);
                exp_cl(1, 1);
            end
            3: begin
                set_x(1, 1, 1, 1);
                set_row(0, 0, 0, 0, 0);
                set_row(1, 0, 0, 0, 0);
                set_row(2, 0, 0, 0, 0);
                set_b(-7, -3, -9);
                exp_wr(0, 0, -7);
                exp_wr(1, 0, -3);
                exp_wr(2, 0, -9);
                exp_cl(1, 1);
            end
            4: begin
                set_x(1, 2, 3, 4);
                set_row(0, -30, -30, -30, -30);
                set_row(1, 1, -1, 1, -1);
                set_row(2, 2, 2, 2, 2);
                set_b(0, 100, -20);
                exp_wr(0, 0, -128);
                exp_wr(1, 98, 98);
                exp_wr(2, 0, 0);
                exp_cl(1, 1);
            end
            default: begin
                set_x(255, 0, 0, 0);
                set_row(0, 1, 0, 0, 0);
                set_row(1, 2, 0, 0, 0);
                set_row(2, -1, 0, 0, 0);
                set_b(0, 0, 0);
                exp_wr(0, 127, -1);
                exp_wr(1, 127, -2);
                exp_wr(2, 0, 1);
                exp_cl(1, 2);
            end
        endcase
    endtask

    task automatic run(input int v, input bit hold, input bit drop);
        int lat;
        load_vec(v);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (lat = 0; lat < 200; lat++) begin
            @(negedge clk);
            if (lat == 3 && drop)
                start = 1'b0;
            if (done[0])
                break;
        end
        chk("done_latency", lat, 19);
        if (hold) begin
            repeat (8) @(negedge clk);
            chk("done_hold", int'(done[0]), 1);
        end
        if (drop) begin
            @(negedge clk);
            chk("done_pulse", int'(done[0]), 0);
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk("done_after_drop", int'(done[0]), 1);
            @(negedge clk);
            chk("done_fall", int'(done[0]), 0);
        end
        chk("writes_drained", wq.size(), 0);
        start = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        for (int k = 0; k < 2; k++)
            chk(nm, int'({busy[k], done[k], out_we[k], in_addr[k], w_addr[k],
                          b_addr[k], out_addr[k], out_data[k], class_idx[k]}), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        run(1, 1'b0, 1'b0);
        run(2, 1'b1, 1'b0);
        run(3, 1'b0, 1'b1);
        run(4, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);

        load_vec(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (9) @(negedge clk);
        chk("busy_mid_run", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        start = 1'b0;
        wq.delete();
        cq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 1'b0, 1'b0);

        chk("class_drained", cq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule

// File: doc/mlp_dense_layer.md
# mlp_dense_layer

Parametrised fully-connected layer engine for the MNIST MLP datapath. It computes `N_OUT` neurons, each as `bias + Σ x·w` over `N_IN` inputs, with optional ReLU, requantisation and saturation, and writes each result to an external activation buffer. It can also report the argmax class, so the same block serves as a hidden layer or as the final classifier. It is controlled by the level start/done handshake used at the board top (start switch, done LED).

## Interface

Parameters:
- `N_IN`, 784, inputs per neuron
- `N_OUT`, 10, neurons in the layer
- `DATA_W`, 8, activation width (in and out)
- `WEIGHT_W`, 8, signed weight width
- `BIAS_W`, 16, signed bias width, at product scale
- `ACC_W`, 32, signed accumulator width
- `FRAC_SHIFT`, 7, arithmetic right shift applied before requantisation
- `RELU`, 1, 1 = clamp negative results to 0
- `IN_UNSIGNED`, 1, 1 = `in_data` is zero-extended, 0 = sign-extended
- Derived: `IDX_W = max(1,$clog2(N_OUT))`, `IN_AW = $clog2(N_IN)`, `W_AW = $clog2(N_IN*N_OUT)`

Ports:
- `CLOCK_50`  in  1  sole clock, rising edge
- `KEY`  in  1  reset, asynchronous, active-low
- `start`  in  1  level request
- `busy`  out  1  high in BIAS/MAC/WRITE
- `done`  out  1  high in DONE
- `in_addr`  out  IN_AW  input activation read address
- `in_data`  in  DATA_W  read data, 1-cycle synchronous latency
- `w_addr`  out  W_AW  weight address, `j*N_IN + i`
- `w_data`  in  WEIGHT_W  signed, 1-cycle latency
- `b_addr`  out  IDX_W  bias address `j`
- `b_data`  in  BIAS_W  signed, 1-cycle latency
- `out_we`  out  1  result write strobe
- `out_addr`  out  IDX_W  neuron index `j`
- `out_data`  out  DATA_W  signed saturated result
- `class_idx`  out  IDX_W  argmax neuron, valid while `done`

## Operation

- States: IDLE, BIAS, MAC, WRITE, DONE.
- IDLE:
  - `start=1` → BIAS with `j=0`.
  - Argmax tracker is cleared.
- BIAS:
  - Drives `b_addr=j`, `in_addr=0`, `w_addr=j*N_IN`.
  - → MAC with `i=0`.
- MAC, cycle `i`:
  - `acc ← (i==0 ? sext(b_data) : acc) + ext(in_data)·w_data`.
  - If `i<N_IN-1`: issues addresses for `i+1`.
  - If `i==N_IN-1`: → WRITE.
- WRITE:
  - `y = acc >>> FRAC_SHIFT`.
  - If `RELU` and `y<0`: `y=0`.
  - `y` saturates to `[-2^(DATA_W-1), 2^(DATA_W-1)-1]`.
  - `out_we=1`, `out_addr=j`, `out_data=y`.
  - Argmax compares the full-precision pre-ReLU `acc` against the best so far with strict `>`, so ties keep the lowest index.
  - If `j==N_OUT-1`: → DONE, and `class_idx` is latched. Otherwise: `j+1`, → BIAS.
- DONE:
  - Holds while `start=1`.
  - `start=0` → IDLE.
- `start` is sampled only in IDLE and DONE. Deasserting it mid-run has no effect.
- Accumulator wraps modulo `2^ACC_W`. No overflow detection; sizing `ACC_W` is the integrator's responsibility.
- Reset asserted mid-run: immediate return to IDLE. No partial-state resume.

## Timing

- Reset values:
  - State IDLE.
  - `busy`, `done`, `out_we` = 0.
  - All address outputs, `out_data` and `class_idx` = 0.
- Per neuron: `N_IN+2` cycles (1 BIAS, `N_IN` MAC, 1 WRITE).
- `done` rises `N_OUT*(N_IN+2)+1` cycles after the edge on which IDLE samples `start=1`. Default configuration: 7861 cycles.
- `out_we` is a single-cycle pulse per neuron, `N_IN+2` cycles apart.
- `done` falls one cycle after `start` is sampled low.
- If `start` was already low at DONE entry, `done` is exactly one cycle wide.
- Back-to-back runs need `start` to be seen low in DONE, then high in IDLE.
- Read addresses are registered. Data for an address issued in cycle `t` is consumed in cycle `t+1`.

## Structure

- `mlp_pkg` holds:
  - the state encoding constants;
  - the saturate/requantise helper function;
  - default `DATA_W`/`WEIGHT_W`/`ACC_W` constants shared with the board top and the other layers.
- Sub-module `mlp_mac_unit` holds the extend, multiply, bias-load and accumulate logic with a `load` and an `en` input.
- Counters, argmax and the FSM stay in `mlp_dense_layer`.

## Test plan

- **Basic sum and latency.** `N_IN=4, N_OUT=3, FRAC_SHIFT=0`, `x=[1,2,3,4]`, row 0 weights all 1, bias 0 → `out_data=10` at `out_addr=0`. `done` rises exactly 19 cycles after `start` is sampled.
- **ReLU and saturation.** `DATA_W=8, FRAC_SHIFT=0`:
  - acc −50 → 0 with `RELU=1`; −50 with `RELU=0`.
  - acc 300 → 127.
  - acc −300 → −128 with `RELU=0`.
- **Argmax.**
  - accs `[5,9,9]` → `class_idx=1`.
  - accs `[-7,-3,-9]` with `RELU=1` → `class_idx=1`, all `out_data=0`.
- **Input extension.** `in_data=8'hFF`, `w=1`, bias 0 → acc 255 with `IN_UNSIGNED=1`; −1 with `IN_UNSIGNED=0`.
- **Handshake.**
  - `start` held high → `done` stays high, no second `out_we`.
  - `start` dropped mid-run → all `N_OUT` writes still occur, `done` high for one cycle.
- **Reset.** `KEY=0` mid-MAC of neuron 1 → all outputs 0 asynchronously. Next start rewrites from `out_addr=0` with correct results.
